control_unit: RTL and testbench

- Hardwired sequencer that drives every control strobe of the 16-bit single-bus datapath: ALU, PC, r0–r3, MAR/MDR/memory, P0/P1 ports, IR and immediate tri-states.
- Fetches each instruction over the bus, decodes the IR contents and issues one micro-step per clock.
- Handshakes with memory through memEN/memRW/MFC.
- The datapath is the responder; this block is the initiator.

---
 rtl/control_unit_if.sv | 29 ++
 rtl/control_unit.sv | 101 ++++++++++
 tb/tb_control_unit.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/control_unit_if.sv
// control_unit_if: strobe bundle between the sequencer and the 16-bit single-bus datapath
interface control_unit_if;
   logic        run;
   logic [15:0] ir;
   logic        MFC;
   logic        ALUin0, ALUin1, ALUOutLatch, ALUOutEn;
   logic        PCOutEn, PCInc;
   logic        r0Latch, r1Latch, r2Latch, r3Latch;
   logic        r0Out, r1Out, r2Out, r3Out;
   logic        memEN, memRW;
   logic        MARin, MDRwriteEN, MDRreadEN, MDRout;
   logic        p0Latch, p0Out, p1Latch, p1Out;
   logic        IREN, ALUImmOut, MOVImmOut;
   logic        halted, err;
   modport master (
      input  run, ir, MFC,
      output ALUin0, ALUin1, ALUOutLatch, ALUOutEn, PCOutEn, PCInc,
             r0Latch, r1Latch, r2Latch, r3Latch, r0Out, r1Out, r2Out, r3Out,
             memEN, memRW, MARin, MDRwriteEN, MDRreadEN, MDRout,
             p0Latch, p0Out, p1Latch, p1Out, IREN, ALUImmOut, MOVImmOut, halted, err
   );
   modport slave (
      output run, ir, MFC,
      input  ALUin0, ALUin1, ALUOutLatch, ALUOutEn, PCOutEn, PCInc,
             r0Latch, r1Latch, r2Latch, r3Latch, r0Out, r1Out, r2Out, r3Out,
             memEN, memRW, MARin, MDRwriteEN, MDRreadEN, MDRout,
             p0Latch, p0Out, p1Latch, p1Out, IREN, ALUImmOut, MOVImmOut, halted, err
   );
endinterface

// File: rtl/control_unit.sv
// control_unit: hardwired fetch/decode/execute sequencer with memory-wait timeout
module control_unit #(
   parameter int MFC_TIMEOUT = 15,
   parameter int TMO_W       = 4
) (
   input logic          clk,
   input logic          rst,
   control_unit_if.master cu
);
   typedef enum logic [4:0] {
      FETCH_ADDR, FETCH_WAIT, FETCH_IR, DECODE,
      ALU_A, ALU_B, ALU_C, ALU_D,
      LD1, LD2, LD3, ST1, ST2, ST3,
      MOVI, OUTP, IN1, IN2, MOVR, HALT, ERROR
   } state_t;
   state_t           state;
   logic [TMO_W-1:0] cnt;
   logic [1:0]       rd, rs;
   logic             waiting, timeout, rd_lat, rd_out, rs_out;
   assign rd      = cu.ir[11:10];
   assign rs      = cu.ir[9:8];
   assign waiting = state inside {FETCH_WAIT, LD2, ST3};
   assign timeout = !cu.MFC && cnt == TMO_W'(MFC_TIMEOUT - 1);
   // state sequencing; the wait counter is held at zero outside wait states so it is clear on entry
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= FETCH_ADDR;
         cnt   <= '0;
      end else begin
         cnt <= (waiting && !cu.MFC) ? cnt + 1'b1 : '0;
         case (state)
            FETCH_ADDR: state <= cu.run ? FETCH_WAIT : FETCH_ADDR;
            FETCH_WAIT: state <= cu.MFC ? FETCH_IR : timeout ? ERROR : FETCH_WAIT;
            FETCH_IR:   state <= DECODE;
            DECODE:
               if (!cu.ir[15]) state <= ALU_A;
               else case (cu.ir[14:12])
                  3'd0:    state <= LD1;
                  3'd1:    state <= ST1;
                  3'd2:    state <= MOVI;
                  3'd3:    state <= OUTP;
                  3'd4:    state <= IN1;
                  3'd5:    state <= MOVR;
                  3'd6:    state <= FETCH_ADDR;
                  default: state <= HALT;
               endcase
            ALU_A:      state <= ALU_B;
            ALU_B:      state <= ALU_C;
            ALU_C:      state <= ALU_D;
            LD1:        state <= LD2;
            LD2:        state <= cu.MFC ? LD3 : timeout ? ERROR : LD2;
            ST1:        state <= ST2;
            ST2:        state <= ST3;
            ST3:        state <= cu.MFC ? FETCH_ADDR : timeout ? ERROR : ST3;
            IN1:        state <= IN2;
            HALT:       state <= HALT;
            ERROR:      state <= ERROR;
            default:    state <= FETCH_ADDR;
         endcase
      end
   end
   // strobe decode from state and ir fields; everything is forced low while reset is held
   always_comb begin
      {cu.ALUin0, cu.ALUin1, cu.ALUOutLatch, cu.ALUOutEn, cu.PCOutEn, cu.PCInc} = '0;
      {cu.memEN, cu.memRW, cu.MARin, cu.MDRwriteEN, cu.MDRreadEN, cu.MDRout} = '0;
      {cu.p0Latch, cu.p0Out, cu.p1Latch, cu.p1Out, cu.IREN, cu.MOVImmOut} = '0;
      {cu.halted, cu.err, rd_lat, rd_out, rs_out} = '0;
      cu.ALUImmOut = 1'b0;
      if (rst) case (state)
         FETCH_ADDR: {cu.PCOutEn, cu.MARin} = {2{cu.run}};
         FETCH_WAIT: {cu.memEN, cu.memRW, cu.MDRreadEN} = {2'b11, cu.MFC};
         FETCH_IR:   {cu.MDRout, cu.IREN, cu.PCInc} = 3'b111;
         ALU_A:      {rd_out, cu.ALUin0} = 2'b11;
         ALU_B:      {rs_out, cu.ALUin1} = 2'b11;
         ALU_C:      cu.ALUOutLatch = 1'b1;
         ALU_D:      {cu.ALUOutEn, rd_lat} = 2'b11;
         LD1:        {rs_out, cu.MARin} = 2'b11;
         LD2:        {cu.memEN, cu.memRW, cu.MDRreadEN} = {2'b11, cu.MFC};
         LD3:        {cu.MDRout, rd_lat} = 2'b11;
         ST1:        {rs_out, cu.MARin} = 2'b11;
         ST2:        {rd_out, cu.MDRwriteEN} = 2'b11;
         ST3:        cu.memEN = 1'b1;
         MOVI:       {cu.MOVImmOut, rd_lat} = 2'b11;
         OUTP:       {rd_out, cu.p0Latch} = 2'b11;
         IN1:        cu.p1Latch = 1'b1;
         IN2:        {cu.p1Out, rd_lat} = 2'b11;
         MOVR:       {rs_out, rd_lat} = 2'b11;
         HALT:       cu.halted = 1'b1;
         ERROR:      cu.err = 1'b1;
         default:    ;
      endcase
      cu.r0Latch = rd_lat && rd == 2'd0;
      cu.r1Latch = rd_lat && rd == 2'd1;
      cu.r2Latch = rd_lat && rd == 2'd2;
      cu.r3Latch = rd_lat && rd == 2'd3;
      cu.r0Out   = (rd_out && rd == 2'd0) || (rs_out && rs == 2'd0);
      cu.r1Out   = (rd_out && rd == 2'd1) || (rs_out && rs == 2'd1);
      cu.r2Out   = (rd_out && rd == 2'd2) || (rs_out && rs == 2'd2);
      cu.r3Out   = (rd_out && rd == 2'd3) || (rs_out && rs == 2'd3);
   end
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: random instruction streams checked against a per-instruction strobe timeline model
module tb_control_unit;
   localparam int AIN0 = 0, AIN1 = 1, AOL = 2, AOE = 3, PCO = 4, PCI = 5, R0L = 6, R0O = 10;
   localparam int MEMEN = 14, MEMRW = 15, MARI = 16, MDRW = 17, MDRR = 18, MDRO = 19;
   localparam int P0L = 20, P0O = 21, P1L = 22, P1O = 23, IREN = 24, AIMM = 25, MIMM = 26;
   localparam int HLT = 27, ERR = 28;
   localparam logic [28:0] BUS = (29'd1 << AOE) | (29'd1 << PCO) | (29'd15 << R0O) |
      (29'd1 << MDRO) | (29'd1 << P0O) | (29'd1 << P1O) | (29'd1 << AIMM) | (29'd1 << MIMM);
   typedef struct {
      logic [15:0] ir;
      logic        mfc;
      logic        run;
      logic [28:0] exp;
      string       tag;
   } step_t;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [28:0] obs;
   step_t       q[$];
   int          checks = 0;
   int          failures = 0;
   control_unit_if cu_if ();
   control_unit #(.MFC_TIMEOUT(15), .TMO_W(4)) dut (.clk(clk), .rst(rst), .cu(cu_if));
   always #5 clk = ~clk;
   assign obs = {cu_if.err, cu_if.halted, cu_if.MOVImmOut, cu_if.ALUImmOut, cu_if.IREN,
                 cu_if.p1Out, cu_if.p1Latch, cu_if.p0Out, cu_if.p0Latch,
                 cu_if.MDRout, cu_if.MDRreadEN, cu_if.MDRwriteEN, cu_if.MARin, cu_if.memRW, cu_if.memEN,
                 cu_if.r3Out, cu_if.r2Out, cu_if.r1Out, cu_if.r0Out,
                 cu_if.r3Latch, cu_if.r2Latch, cu_if.r1Latch, cu_if.r0Latch,
                 cu_if.PCInc, cu_if.PCOutEn, cu_if.ALUOutEn, cu_if.ALUOutLatch, cu_if.ALUin1, cu_if.ALUin0};
   function automatic logic [28:0] b(input int i);
      return 29'd1 << i;
   endfunction
   function automatic logic rb();
      return 1'($urandom);
   endfunction
   task automatic chk(input string tag, input logic [28:0] o, input logic [28:0] e);
      checks++;
      assert (o === e) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, o, e);
      end
   endtask
   task automatic drive_check(input step_t s);
      cu_if.ir  = s.ir;
      cu_if.MFC = s.mfc;
      cu_if.run = s.run;
      @(negedge clk);
      chk(s.tag, obs, s.exp);
      checks++;
      assert (($countones(obs & BUS) <= 1) === 1'b1) else begin
         failures++;
         $error("FAIL busdrv_%s observed=%h expected_at_most_one_driver", s.tag, obs & BUS);
      end
      @(posedge clk);
      #1;
   endtask
   task automatic push(input logic [15:0] ir, input logic mfc, input logic run, input logic [28:0] e, input string tag);
      step_t s;
      s.ir = ir; s.mfc = mfc; s.run = run; s.exp = e; s.tag = tag;
      q.push_back(s);
   endtask
   task automatic run_q();
      while (q.size() > 0) drive_check(q.pop_front());
   endtask
   // one memory wait of df cycles: MFC arrives in the last cycle, with MDRreadEN then if it is a read
   task automatic mem_wait(input logic [15:0] ir, input int df, input logic rd_cyc, input string tag);
      for (int i = 1; i <= df; i++)
         push(ir, i == df, rb(), b(MEMEN) | (rd_cyc ? b(MEMRW) : '0) | ((i == df && rd_cyc) ? b(MDRR) : '0), tag);
   endtask
   // expected cycle-by-cycle strobes for one instruction, from idle FETCH_ADDR to the next FETCH_ADDR
   task automatic plan(input logic [15:0] iv, input int df, input int de, input int idle);
      int rd, rs;
      rd = int'(iv[11:10]);
      rs = int'(iv[9:8]);
      repeat (idle) push(16'($urandom), rb(), 1'b0, '0, "idle");
      push(16'($urandom), rb(), 1'b1, b(PCO) | b(MARI), "fetch_addr");
      mem_wait(16'($urandom), df, 1'b1, "fetch_wait");
      push(16'($urandom), rb(), rb(), b(MDRO) | b(IREN) | b(PCI), "fetch_ir");
      push(iv, rb(), rb(), '0, "decode");
      if (!iv[15]) begin
         push(iv, rb(), rb(), b(R0O + rd) | b(AIN0), "alu_a");
         push(iv, rb(), rb(), b(R0O + rs) | b(AIN1), "alu_b");
         push(iv, rb(), rb(), b(AOL), "alu_c");
         push(iv, rb(), rb(), b(AOE) | b(R0L + rd), "alu_d");
      end else case (iv[14:12])
         3'd0: begin
            push(iv, rb(), rb(), b(R0O + rs) | b(MARI), "load_1");
            mem_wait(iv, de, 1'b1, "load_2");
            push(iv, rb(), rb(), b(MDRO) | b(R0L + rd), "load_3");
         end
         3'd1: begin
            push(iv, rb(), rb(), b(R0O + rs) | b(MARI), "store_1");
            push(iv, rb(), rb(), b(R0O + rd) | b(MDRW), "store_2");
            mem_wait(iv, de, 1'b0, "store_3");
         end
         3'd2: push(iv, rb(), rb(), b(MIMM) | b(R0L + rd), "movi");
         3'd3: push(iv, rb(), rb(), b(R0O + rd) | b(P0L), "out");
         3'd4: begin
            push(iv, rb(), rb(), b(P1L), "in_1");
            push(iv, rb(), rb(), b(P1O) | b(R0L + rd), "in_2");
         end
         3'd5: push(iv, rb(), rb(), b(R0O + rs) | b(R0L + rd), "mov");
         default: ;
      endcase
   endtask
   task automatic reset_pulse(input string tag);
      rst = 1'b0;
      #1;
      chk(tag, obs, '0);
      @(posedge clk);
      #1;
      chk({tag, "_held"}, obs, '0);
      rst = 1'b1;
   endtask
   initial begin
      logic [15:0] iv;
      cu_if.run = 1'b1;
      cu_if.MFC = 1'b1;
      cu_if.ir  = 16'h0600;
      #2;
      chk("reset", obs, '0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      plan(16'h0600, 2, 1, 0);
      plan(16'h8C00, 1, 3, 1);
      plan(16'h9400, 1, 1, 0);
      plan(16'hC000, 1, 1, 2);
      plan(16'hBD00, 1, 1, 0);
      plan(16'hE000, 3, 1, 0);
      run_q();
      repeat (60) begin
         iv = 16'($urandom);
         if ($urandom_range(0, 7) != 0) iv[15:12] = {1'b1, 3'($urandom_range(0, 6))};
         else iv[15] = 1'b0;
         plan(iv, $urandom_range(1, 4), $urandom_range(1, 4), $urandom_range(0, 2));
         run_q();
      end
      push(16'($urandom), rb(), 1'b1, b(PCO) | b(MARI), "tmo_fetch_addr");
      repeat (15) push(16'($urandom), 1'b0, rb(), b(MEMEN) | b(MEMRW), "tmo_wait");
      repeat (5) push(16'($urandom), rb(), rb(), b(ERR), "tmo_err");
      run_q();
      reset_pulse("err_reset");
      plan(16'h8000, 14, 15, 0);
      repeat (14) push(16'h8000, 1'b0, rb(), b(MEMEN) | b(MEMRW), "load_tmo_wait");
      push(16'h8000, 1'b0, rb(), b(MEMEN) | b(MEMRW), "load_tmo_last");
      push(16'h8000, rb(), rb(), b(ERR), "load_tmo_err");
      while (q.size() > 0 && q[q.size() - 1].tag != "load_1") void'(q.pop_back());
      q.push_back('{16'h8000, 1'b0, 1'b1, '0, "unused"});
      void'(q.pop_back());
      run_q();
      for (int i = 0; i < 14; i++) push(16'h8000, 1'b0, rb(), b(MEMEN) | b(MEMRW), "load_tmo_wait");
      push(16'h8000, 1'b0, rb(), b(MEMEN) | b(MEMRW), "load_tmo_last");
      push(16'h8000, rb(), rb(), b(ERR), "load_tmo_err");
      run_q();
      reset_pulse("err2_reset");
      plan(16'hF000, 1, 1, 0);
      repeat (20) push(16'($urandom), rb(), rb(), b(HLT), "halt");
      run_q();
      reset_pulse("halt_reset");
      plan(16'h8C00, 1, 5, 0);
      repeat (5) void'(q.pop_back());
      run_q();
      cu_if.ir  = 16'h8C00;
      cu_if.MFC = 1'b0;
      #2;
      chk("ld2_before_async", obs, b(MEMEN) | b(MEMRW));
      rst = 1'b0;
      #1;
      chk("async_reset", obs, '0);
      @(posedge clk);
      #1;
      chk("async_reset_held", obs, '0);
      rst = 1'b1;
      plan(16'h6D00, 1, 1, 0);
      plan(16'h9B00, 2, 2, 0);
      run_q();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
